// File: rtl/osd_him_host_end.sv
// Host-side end of the GLIP link: packs DII packets into length-prefixed GLIP words and rebuilds them on receive.
// Optional statistics counters are built when OSD_HIM_HOST_STATS_EN is defined.
package osd_him_host_end_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module osd_him_host_end
    import osd_him_host_end_pkg::*;
#(
    parameter int unsigned MAX_PKT_LEN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  dii_flit     dii_in,
    output logic        dii_in_ready,
    output logic [15:0] glip_out_data,
    output logic        glip_out_valid,
    input  logic        glip_out_ready,
    input  logic [15:0] glip_in_data,
    input  logic        glip_in_valid,
    output logic        glip_in_ready,
    output dii_flit     dii_out,
    input  logic        dii_out_ready,
    output logic        tx_err_oversize,
    output logic        rx_err_len,
    output logic [15:0] stat_tx_pkts,
    output logic [15:0] stat_rx_pkts,
    output logic [15:0] stat_errs
);

    localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN) + 1;
    localparam int unsigned IDX_W = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_PKT_LEN);
    localparam logic [15:0]      MAX_LEN16 = 16'(MAX_PKT_LEN);

    typedef enum logic [1:0] {TX_FILL, TX_SEND_HDR, TX_SEND_PAY} tx_state_e;
    typedef enum logic [1:0] {RX_HDR, RX_PAY, RX_DROP} rx_state_e;

    tx_state_e        tx_state, tx_state_nxt;
    rx_state_e        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] tx_rd;
    logic             tx_ovf;
    logic [15:0]      tx_buf [MAX_PKT_LEN];
    logic [15:0]      rx_rem;

    logic tx_acc, tx_full, tx_hs, tx_pkt_done, tx_pay_last;
    logic rx_hs, rx_pay_last, rx_drop_last;

    always_comb begin
        tx_acc      = dii_in_ready & dii_in.valid;
        tx_full     = (tx_cnt == MAX_CNT);
        tx_hs       = glip_out_valid & glip_out_ready;
        tx_pkt_done = tx_acc & dii_in.last & ~tx_ovf & ~tx_full;
        tx_pay_last = (tx_state == TX_SEND_PAY) & tx_hs & (tx_rd == (tx_cnt - CNT_W'(1)));
        rx_hs        = glip_in_valid & glip_in_ready;
        rx_pay_last  = (rx_state == RX_PAY) & rx_hs & (rx_rem == 16'd0);
        rx_drop_last = (rx_state == RX_DROP) & rx_hs & (rx_rem == 16'd0);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_FILL;
            rx_state <= RX_HDR;
        end else begin
            tx_state <= tx_state_nxt;
            rx_state <= rx_state_nxt;
        end
    end

    // TX next state
    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_FILL:     if (tx_pkt_done) tx_state_nxt = TX_SEND_HDR;
            TX_SEND_HDR: if (tx_hs)       tx_state_nxt = TX_SEND_PAY;
            TX_SEND_PAY: if (tx_pay_last) tx_state_nxt = TX_FILL;
            default:                      tx_state_nxt = TX_FILL;
        endcase
    end

    // TX outputs; everything is held quiet while reset is asserted
    always_comb begin
        dii_in_ready    = 1'b0;
        glip_out_valid  = 1'b0;
        glip_out_data   = 16'd0;
        tx_err_oversize = 1'b0;
        if (!rst) begin
            case (tx_state)
                TX_FILL: begin
                    dii_in_ready    = 1'b1;
                    tx_err_oversize = dii_in.valid & dii_in.last & (tx_ovf | tx_full);
                end
                TX_SEND_HDR: begin
                    glip_out_valid = 1'b1;
                    glip_out_data  = 16'(tx_cnt);
                end
                TX_SEND_PAY: begin
                    glip_out_valid = 1'b1;
                    glip_out_data  = tx_buf[tx_rd[IDX_W-1:0]];
                end
                default: ;
            endcase
        end
    end

    // TX counters; an oversize packet is swallowed up to its last flit
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt <= '0;
            tx_rd  <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (tx_acc) begin
                if (tx_ovf || tx_full) begin
                    tx_ovf <= ~dii_in.last;
                    if (dii_in.last) tx_cnt <= '0;
                end else begin
                    tx_cnt <= tx_cnt + CNT_W'(1);
                end
            end
            if (tx_state == TX_SEND_HDR && tx_hs) tx_rd <= '0;
            if (tx_state == TX_SEND_PAY && tx_hs) tx_rd <= tx_rd + CNT_W'(1);
            if (tx_pay_last) tx_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_acc && !tx_ovf && !tx_full) tx_buf[tx_cnt[IDX_W-1:0]] <= dii_in.data;
    end

    // RX next state
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_HDR: begin
                if (rx_hs && glip_in_data != 16'd0) begin
                    rx_state_nxt = (glip_in_data > MAX_LEN16) ? RX_DROP : RX_PAY;
                end
            end
            RX_PAY:  if (rx_pay_last)  rx_state_nxt = RX_HDR;
            RX_DROP: if (rx_drop_last) rx_state_nxt = RX_HDR;
            default:                   rx_state_nxt = RX_HDR;
        endcase
    end

    // RX outputs; payload is cut through combinationally
    always_comb begin
        glip_in_ready = 1'b0;
        dii_out       = '0;
        rx_err_len    = 1'b0;
        if (!rst) begin
            case (rx_state)
                RX_HDR: begin
                    glip_in_ready = 1'b1;
                    rx_err_len    = glip_in_valid &
                                    ((glip_in_data == 16'd0) | (glip_in_data > MAX_LEN16));
                end
                RX_PAY: begin
                    glip_in_ready = dii_out_ready;
                    dii_out.valid = glip_in_valid;
                    dii_out.last  = (rx_rem == 16'd0);
                    dii_out.data  = glip_in_data;
                end
                RX_DROP: glip_in_ready = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rem <= 16'd0;
        end else if (rx_hs) begin
            rx_rem <= (rx_state == RX_HDR) ? (glip_in_data - 16'd1) : (rx_rem - 16'd1);
        end
    end

`ifdef OSD_HIM_HOST_STATS_EN
    logic [16:0] err_sum;

    always_comb err_sum = 17'(stat_errs) + 17'(tx_err_oversize) + 17'(rx_err_len);

    // Saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_tx_pkts <= 16'd0;
            stat_rx_pkts <= 16'd0;
            stat_errs    <= 16'd0;
        end else begin
            if (tx_pay_last && stat_tx_pkts != 16'hFFFF) stat_tx_pkts <= stat_tx_pkts + 16'd1;
            if (rx_pay_last && stat_rx_pkts != 16'hFFFF) stat_rx_pkts <= stat_rx_pkts + 16'd1;
            stat_errs <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`else
    assign stat_tx_pkts = 16'd0;
    assign stat_rx_pkts = 16'd0;
    assign stat_errs    = 16'd0;
`endif

endmodule

// File: tb/tb_osd_him_host_end.sv
// Bench for osd_him_host_end: table-driven TX/RX packets checked through output scoreboards.
module tb_osd_him_host_end;
    import osd_him_host_end_pkg::*;

`ifdef OSD_HIM_HOST_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    dii_flit     dii_in;
    logic        dii_in_ready;
    logic [15:0] glip_out_data;
    logic        glip_out_valid;
    logic        glip_out_ready = 1'b1;
    logic [15:0] glip_in_data;
    logic        glip_in_valid;
    logic        glip_in_ready;
    dii_flit     dii_out;
    logic        dii_out_ready = 1'b1;
    logic        tx_err_oversize, rx_err_len;
    logic [15:0] stat_tx_pkts, stat_rx_pkts, stat_errs;

    int total = 0, bad = 0;
    int n_tx_err = 0, n_rx_err = 0;
    int tx_pkts_exp = 0, rx_pkts_exp = 0, errs_exp = 0;
    bit tx_stall = 1'b0, rx_toggle = 1'b0;
    logic [15:0] exp_glip[$];
    logic [16:0] exp_dii[$];

    typedef struct {
        int          len;
        logic [15:0] base;
        bit          err;
        bit          stress;
    } pkt_vec_t;

    pkt_vec_t tv[6];
    pkt_vec_t rv[7];

    osd_him_host_end #(.MAX_PKT_LEN(12)) dut (
        .clk(clk), .rst(rst),
        .dii_in(dii_in), .dii_in_ready(dii_in_ready),
        .glip_out_data(glip_out_data), .glip_out_valid(glip_out_valid), .glip_out_ready(glip_out_ready),
        .glip_in_data(glip_in_data), .glip_in_valid(glip_in_valid), .glip_in_ready(glip_in_ready),
        .dii_out(dii_out), .dii_out_ready(dii_out_ready),
        .tx_err_oversize(tx_err_oversize), .rx_err_len(rx_err_len),
        .stat_tx_pkts(stat_tx_pkts), .stat_rx_pkts(stat_rx_pkts), .stat_errs(stat_errs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        glip_out_ready = tx_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        dii_out_ready  = rx_toggle ? ~dii_out_ready : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Output monitors: handshakes are popped against the expected queues
    always @(negedge clk) begin
        if (!rst) begin
            if (glip_out_valid && glip_out_ready) begin
                if (exp_glip.size() == 0) begin
                    total++; bad++;
                    $display("FAIL glip_out_unexpected act=%h exp=none", glip_out_data);
                end else check("glip_out", 32'(glip_out_data), 32'(exp_glip.pop_front()));
            end
            if (dii_out.valid && dii_out_ready) begin
                if (exp_dii.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dii_out_unexpected act=%h exp=none", {dii_out.last, dii_out.data});
                end else check("dii_out", 32'({dii_out.last, dii_out.data}), 32'(exp_dii.pop_front()));
            end
            if (dii_out.valid && !dii_out_ready) check("rx_stall_ready", 32'(glip_in_ready), 32'd0);
            if (tx_err_oversize) n_tx_err++;
            if (rx_err_len) n_rx_err++;
        end
    end

    task automatic tx_flit(input logic [15:0] d, input logic l);
        int n = 0;
        dii_in.data = d; dii_in.last = l; dii_in.valid = 1'b1;
        @(negedge clk);
        while (!dii_in_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin total++; bad++; $display("FAIL tx_accept_timeout act=0 exp=1"); end
        @(posedge clk); #1;
        dii_in.valid = 1'b0;
    endtask

    task automatic rx_word(input logic [15:0] w);
        int n = 0;
        glip_in_data = w; glip_in_valid = 1'b1;
        @(negedge clk);
        while (!glip_in_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin total++; bad++; $display("FAIL rx_accept_timeout act=0 exp=1"); end
        @(posedge clk); #1;
        glip_in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((exp_glip.size() != 0 || exp_dii.size() != 0) && n < bound) begin
            @(posedge clk); n++;
        end
        #1;
        check("drain", 32'(exp_glip.size() + exp_dii.size()), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_stats(input int tx_e, input int rx_e, input int er_e);
        check("stat_tx_pkts", 32'(stat_tx_pkts), STATS ? 32'(tx_e) : 32'd0);
        check("stat_rx_pkts", 32'(stat_rx_pkts), STATS ? 32'(rx_e) : 32'd0);
        check("stat_errs",    32'(stat_errs),    STATS ? 32'(er_e) : 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    initial begin
        int e0;
        tv[0] = '{3,  16'h00A1, 1'b0, 1'b0};
        tv[1] = '{14, 16'h1400, 1'b1, 1'b0};
        tv[2] = '{1,  16'h0055, 1'b0, 1'b0};
        tv[3] = '{12, 16'h1200, 1'b0, 1'b1};
        tv[4] = '{13, 16'h1300, 1'b1, 1'b0};
        tv[5] = '{5,  16'h0B00, 1'b0, 1'b1};
        rv[0] = '{2,  16'h00B1, 1'b0, 1'b1};
        rv[1] = '{0,  16'h0000, 1'b1, 1'b0};
        rv[2] = '{1,  16'h00C1, 1'b0, 1'b0};
        rv[3] = '{15, 16'h1500, 1'b1, 1'b0};
        rv[4] = '{1,  16'h00D1, 1'b0, 1'b0};
        rv[5] = '{12, 16'h2200, 1'b0, 1'b1};
        rv[6] = '{13, 16'h2300, 1'b1, 1'b0};

        rst = 1'b1; dii_in = '0; glip_in_valid = 1'b0; glip_in_data = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dii_in_ready", 32'(dii_in_ready), 32'd0);
        check("rst_glip_in_ready", 32'(glip_in_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("init_dii_in_ready", 32'(dii_in_ready), 32'd1);
        check("init_glip_out_valid", 32'(glip_out_valid), 32'd0);
        check("init_glip_in_ready", 32'(glip_in_ready), 32'd1);
        check("init_dii_out", 32'({dii_out.valid, dii_out.last}), 32'd0);
        check("init_errs", 32'({tx_err_oversize, rx_err_len}), 32'd0);
        check_stats(0, 0, 0);
        @(posedge clk); #1;

        // 3-flit packet: back-to-back GLIP words and input blocked while sending
        exp_glip.push_back(16'h0003);
        exp_glip.push_back(16'h00A1); exp_glip.push_back(16'h00A2); exp_glip.push_back(16'h00A3);
        tx_flit(16'h00A1, 1'b0); tx_flit(16'h00A2, 1'b0); tx_flit(16'h00A3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_busy", 32'({dii_in_ready, glip_out_valid}), 32'b01);
        end
        @(negedge clk);
        check("t1_refill", 32'(dii_in_ready), 32'd1);
        @(posedge clk); #1;
        drain(50);
        tx_pkts_exp++;

        for (int k = 0; k < 6; k++) begin
            tx_stall = tv[k].stress;
            e0 = n_tx_err;
            if (!tv[k].err) begin
                exp_glip.push_back(16'(tv[k].len));
                for (int i = 0; i < tv[k].len; i++) exp_glip.push_back(tv[k].base + 16'(i));
                tx_pkts_exp++;
            end else errs_exp++;
            for (int i = 0; i < tv[k].len; i++) tx_flit(tv[k].base + 16'(i), i == tv[k].len - 1);
            drain(400);
            check("tx_err_pulses", 32'(n_tx_err - e0), 32'(tv[k].err));
            tx_stall = 1'b0;
        end

        for (int k = 0; k < 7; k++) begin
            rx_toggle = rv[k].stress;
            e0 = n_rx_err;
            if (!rv[k].err) begin
                for (int i = 0; i < rv[k].len; i++)
                    exp_dii.push_back({i == rv[k].len - 1, rv[k].base + 16'(i)});
                rx_pkts_exp++;
            end else errs_exp++;
            rx_word(16'(rv[k].len));
            for (int i = 0; i < rv[k].len; i++) rx_word(rv[k].base + 16'(i));
            drain(200);
            check("rx_err_pulses", 32'(n_rx_err - e0), 32'(rv[k].err));
            rx_toggle = 1'b0;
        end
        check_stats(tx_pkts_exp, rx_pkts_exp, errs_exp);

        // Reset after the first payload word abandons the packet
        exp_glip.push_back(16'h0004); exp_glip.push_back(16'h0071);
        tx_flit(16'h0071, 1'b0); tx_flit(16'h0072, 1'b0); tx_flit(16'h0073, 1'b0); tx_flit(16'h0074, 1'b1);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 32'(glip_out_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(glip_out_valid), 32'd0);
        check("post_rst_ready", 32'(dii_in_ready), 32'd1);
        check_stats(0, 0, 0);
        @(posedge clk); #1;
        check("rst_partial_words", 32'(exp_glip.size()), 32'd0);
        repeat (3) begin @(posedge clk); #1; end

        exp_glip.push_back(16'h0002); exp_glip.push_back(16'h0081); exp_glip.push_back(16'h0082);
        tx_flit(16'h0081, 1'b0); tx_flit(16'h0082, 1'b1);
        drain(50);
        exp_dii.push_back({1'b1, 16'h00E1});
        rx_word(16'h0001); rx_word(16'h00E1);
        drain(50);
        check_stats(1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
